// File: rtl/neuron_config_loader.sv
// Host-side writer for the neuron weight/bias configuration bus.
// Parses header/weights/bias records from a 32-bit valid/ready stream and drives the broadcast config bus.
module neuron_config_loader #(
  parameter int unsigned dataWidth  = 16,
  parameter int unsigned maxWeight  = 784,
  parameter int unsigned countWidth = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  weightValid,
  output logic [31:0]           weightValue,
  output logic                  biasValid,
  output logic [31:0]           biasValue,
  output logic [31:0]           config_layer_num,
  output logic [31:0]           config_neuron_num,
  output logic                  busy,
  output logic [countWidth-1:0] loaded_count,
  output logic                  hdr_error
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned WCNT_W  = 16;
  localparam int unsigned LAYER_W = 6;
  localparam int unsigned NEUR_W  = 10;
  localparam int unsigned MAX_W   = maxWeight;

  // Word payloads pass through untouched, so the neuron data width must fit a word.
  if (dataWidth < 1 || dataWidth > WORD_W) begin : g_bad_data_width
    $error("neuron_config_loader: dataWidth must be 1..32");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WEIGHT = 2'd1,
    ST_BIAS   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
  logic                    s_ready_q, s_ready_d;
  logic                    weight_valid_q, weight_valid_d;
  logic [WORD_W-1:0]       weight_value_q, weight_value_d;
  logic                    bias_valid_q, bias_valid_d;
  logic [WORD_W-1:0]       bias_value_q, bias_value_d;
  logic [WORD_W-1:0]       layer_q, layer_d;
  logic [WORD_W-1:0]       neuron_q, neuron_d;
  logic [countWidth-1:0]   loaded_count_q, loaded_count_d;
  logic                    hdr_error_q, hdr_error_d;

  logic                    xfer;
  logic [LAYER_W-1:0]      hdr_layer;
  logic [NEUR_W-1:0]       hdr_neuron;
  logic [WCNT_W-1:0]       hdr_count;
  logic                    hdr_legal;

  assign xfer       = s_valid && s_ready_q;
  assign hdr_layer  = s_data[31:26];
  assign hdr_neuron = s_data[25:16];
  assign hdr_count  = s_data[15:0];
  assign hdr_legal  = (WORD_W'(hdr_count) <= MAX_W);

  // Next-state and output computation; strobes default low so they last one cycle.
  always_comb begin
    state_d         = state_q;
    wcnt_d          = wcnt_q;
    s_ready_d       = 1'b1;
    weight_valid_d  = 1'b0;
    weight_value_d  = weight_value_q;
    bias_valid_d    = 1'b0;
    bias_value_d    = bias_value_q;
    layer_d         = layer_q;
    neuron_d        = neuron_q;
    loaded_count_d  = loaded_count_q;
    hdr_error_d     = hdr_error_q;

    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (hdr_legal) begin
            layer_d  = WORD_W'(hdr_layer);
            neuron_d = WORD_W'(hdr_neuron);
            wcnt_d   = hdr_count;
            state_d  = (hdr_count == WCNT_W'(0)) ? ST_BIAS : ST_WEIGHT;
          end else begin
            hdr_error_d = 1'b1;
          end
        end
      end
      ST_WEIGHT: begin
        if (xfer) begin
          weight_value_d = s_data;
          weight_valid_d = 1'b1;
          wcnt_d         = wcnt_q - WCNT_W'(1);
          if (wcnt_q == WCNT_W'(1)) begin
            state_d = ST_BIAS;
          end
        end
      end
      ST_BIAS: begin
        if (xfer) begin
          bias_value_d   = s_data;
          bias_valid_d   = 1'b1;
          loaded_count_d = loaded_count_q + countWidth'(1);
          state_d        = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any record in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      wcnt_q         <= '0;
      s_ready_q      <= 1'b0;
      weight_valid_q <= 1'b0;
      weight_value_q <= '0;
      bias_valid_q   <= 1'b0;
      bias_value_q   <= '0;
      layer_q        <= '0;
      neuron_q       <= '0;
      loaded_count_q <= '0;
      hdr_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      s_ready_q      <= s_ready_d;
      weight_valid_q <= weight_valid_d;
      weight_value_q <= weight_value_d;
      bias_valid_q   <= bias_valid_d;
      bias_value_q   <= bias_value_d;
      layer_q        <= layer_d;
      neuron_q       <= neuron_d;
      loaded_count_q <= loaded_count_d;
      hdr_error_q    <= hdr_error_d;
    end
  end

  assign s_ready           = s_ready_q;
  assign weightValid       = weight_valid_q;
  assign weightValue       = weight_value_q;
  assign biasValid         = bias_valid_q;
  assign biasValue         = bias_value_q;
  assign config_layer_num  = layer_q;
  assign config_neuron_num = neuron_q;
  assign busy              = (state_q != ST_IDLE);
  assign loaded_count      = loaded_count_q;
  assign hdr_error         = hdr_error_q;

endmodule

// File: tb/tb_neuron_config_loader.sv
// Directed bench for neuron_config_loader: vector table plus reset-abort, max-N and counter-wrap sequences.
module tb_neuron_config_loader;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic [31:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic          weightValid;
  logic [31:0]   weightValue;
  logic          biasValid;
  logic [31:0]   biasValue;
  logic [31:0]   config_layer_num;
  logic [31:0]   config_neuron_num;
  logic          busy;
  logic [CW-1:0] loaded_count;
  logic          hdr_error;

  int tests;
  int fails;

  neuron_config_loader #(
    .dataWidth (16),
    .maxWeight (784),
    .countWidth(CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .weightValid      (weightValid),
    .weightValue      (weightValue),
    .biasValid        (biasValid),
    .biasValue        (biasValue),
    .config_layer_num (config_layer_num),
    .config_neuron_num(config_neuron_num),
    .busy             (busy),
    .loaded_count     (loaded_count),
    .hdr_error        (hdr_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [31:0]   d;
    logic          wv;
    logic [31:0]   wval;
    logic          bv;
    logic [31:0]   bval;
    logic [31:0]   lay;
    logic [31:0]   neu;
    logic          bsy;
    logic [CW-1:0] cnt;
    logic          herr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [31:0] d,
                              input logic wv, input logic [31:0] wval,
                              input logic bv, input logic [31:0] bval,
                              input logic [31:0] lay, input logic [31:0] neu,
                              input logic bsy, input int cnt, input logic herr);
    vec_t r;
    r.v = v; r.d = d; r.wv = wv; r.wval = wval; r.bv = bv; r.bval = bval;
    r.lay = lay; r.neu = neu; r.bsy = bsy; r.cnt = CW'(cnt); r.herr = herr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rdy, input vec_t e);
    chk({tag, ".s_ready"},     32'(s_ready),           32'(rdy));
    chk({tag, ".weightValid"}, 32'(weightValid),       32'(e.wv));
    chk({tag, ".weightValue"}, weightValue,            e.wval);
    chk({tag, ".biasValid"},   32'(biasValid),         32'(e.bv));
    chk({tag, ".biasValue"},   biasValue,              e.bval);
    chk({tag, ".layer"},       config_layer_num,       e.lay);
    chk({tag, ".neuron"},      config_neuron_num,      e.neu);
    chk({tag, ".busy"},        32'(busy),              32'(e.bsy));
    chk({tag, ".count"},       32'(loaded_count),      32'(e.cnt));
    chk({tag, ".hdr_error"},   32'(hdr_error),         32'(e.herr));
  endtask

  // Drive one word (or idle) away from the edge, then sample just after the edge.
  task automatic step(input logic v, input logic [31:0] d);
    @(negedge clk);
    s_valid = v;
    s_data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t zero;
    int   wpulses;
    tests = 0;
    fails = 0;
    rst = 1'b0;
    s_valid = 1'b0;
    s_data = 32'h0;
    zero = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Legal record; stall record; N=0; illegal header then legal; back-to-back pair.
    vecs.push_back(mk(1, 32'h0403_0003, 0, 32'h00, 0, 32'h00, 1, 3, 1, 0, 0));
    vecs.push_back(mk(1, 32'h11,        1, 32'h11, 0, 32'h00, 1, 3, 1, 0, 0));
    vecs.push_back(mk(1, 32'h22,        1, 32'h22, 0, 32'h00, 1, 3, 1, 0, 0));
    vecs.push_back(mk(1, 32'h33,        1, 32'h33, 0, 32'h00, 1, 3, 1, 0, 0));
    vecs.push_back(mk(1, 32'h7F,        0, 32'h33, 1, 32'h7F, 1, 3, 0, 1, 0));
    vecs.push_back(mk(0, 32'h00,        0, 32'h33, 0, 32'h7F, 1, 3, 0, 1, 0));
    vecs.push_back(mk(1, 32'h0403_0003, 0, 32'h33, 0, 32'h7F, 1, 3, 1, 1, 0));
    vecs.push_back(mk(1, 32'h11,        1, 32'h11, 0, 32'h7F, 1, 3, 1, 1, 0));
    vecs.push_back(mk(1, 32'h22,        1, 32'h22, 0, 32'h7F, 1, 3, 1, 1, 0));
    vecs.push_back(mk(0, 32'hDEAD,      0, 32'h22, 0, 32'h7F, 1, 3, 1, 1, 0));
    vecs.push_back(mk(0, 32'hBEEF,      0, 32'h22, 0, 32'h7F, 1, 3, 1, 1, 0));
    vecs.push_back(mk(1, 32'h33,        1, 32'h33, 0, 32'h7F, 1, 3, 1, 1, 0));
    vecs.push_back(mk(1, 32'h7F,        0, 32'h33, 1, 32'h7F, 1, 3, 0, 2, 0));
    vecs.push_back(mk(1, 32'h0008_0000, 0, 32'h33, 0, 32'h7F, 0, 8, 1, 2, 0));
    vecs.push_back(mk(1, 32'h05,        0, 32'h33, 1, 32'h05, 0, 8, 0, 3, 0));
    vecs.push_back(mk(1, 32'h0000_0311, 0, 32'h33, 0, 32'h05, 0, 8, 0, 3, 1));
    vecs.push_back(mk(1, 32'h0C05_0001, 0, 32'h33, 0, 32'h05, 3, 5, 1, 3, 1));
    vecs.push_back(mk(1, 32'hAA,        1, 32'hAA, 0, 32'h05, 3, 5, 1, 3, 1));
    vecs.push_back(mk(1, 32'hBB,        0, 32'hAA, 1, 32'hBB, 3, 5, 0, 4, 1));
    vecs.push_back(mk(1, 32'h0000_0002, 0, 32'hAA, 0, 32'hBB, 0, 0, 1, 4, 1));
    vecs.push_back(mk(1, 32'h01,        1, 32'h01, 0, 32'hBB, 0, 0, 1, 4, 1));
    vecs.push_back(mk(1, 32'h02,        1, 32'h02, 0, 32'hBB, 0, 0, 1, 4, 1));
    vecs.push_back(mk(1, 32'h03,        0, 32'h02, 1, 32'h03, 0, 0, 0, 5, 1));
    vecs.push_back(mk(1, 32'h0805_0001, 0, 32'h02, 0, 32'h03, 2, 5, 1, 5, 1));
    vecs.push_back(mk(1, 32'h04,        1, 32'h04, 0, 32'h03, 2, 5, 1, 5, 1));
    vecs.push_back(mk(1, 32'h06,        0, 32'h04, 1, 32'h06, 2, 5, 0, 6, 1));
    vecs.push_back(mk(0, 32'h00,        0, 32'h04, 0, 32'h06, 2, 5, 0, 6, 1));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, zero);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_out("post_reset", 1'b1, zero);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].d);
      chk_out($sformatf("vec%0d", i), 1'b1, vecs[i]);
    end

    // Largest legal weight count: layer 4, neuron 0, N=784
    step(1'b1, 32'h1000_0310);
    chk_out("nmax_hdr", 1'b1, mk(1, 32'h1000_0310, 0, 32'h04, 0, 32'h06, 4, 0, 1, 6, 1));
    wpulses = 0;
    for (int i = 1; i <= 784; i++) begin
      step(1'b1, 32'(i));
      if (weightValid) wpulses++;
    end
    chk("nmax_pulses", 32'(wpulses), 32'd784);
    chk("nmax_busy", 32'(busy), 32'd1);
    step(1'b1, 32'h1234);
    chk_out("nmax_bias", 1'b1, mk(1, 32'h1234, 0, 32'd784, 1, 32'h1234, 4, 0, 0, 7, 1));

    // Reset after the 2nd weight of an N=4 record, asserted between edges
    step(1'b1, 32'h0401_0004);
    step(1'b1, 32'hA1);
    step(1'b1, 32'hA2);
    chk("abort_pre_wv", 32'(weightValid), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk_out("abort_async", 1'b0, zero);
    @(posedge clk);
    #1;
    chk_out("abort_held", 1'b0, zero);
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b1;
    s_data = 32'h0C07_0000;
    @(posedge clk);
    #1;
    chk_out("release_edge", 1'b1, zero);
    @(posedge clk);
    #1;
    chk_out("release_hdr", 1'b1, mk(1, 0, 0, 0, 0, 0, 3, 7, 1, 0, 0));
    step(1'b1, 32'h99);
    chk_out("release_bias", 1'b1, mk(1, 0, 0, 0, 1, 32'h99, 3, 7, 0, 1, 0));

    // loaded_count wraps: 15 more N=0 records bring 1 back round to 0
    for (int r = 0; r < 15; r++) begin
      step(1'b1, 32'h0000_0000);
      step(1'b1, 32'(r));
    end
    chk("wrap_count", 32'(loaded_count), 32'd0);
    chk("wrap_bias", biasValue, 32'd14);
    step(1'b0, 32'h0);
    chk("wrap_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
